// File: rtl/conv_window_controller.sv
// conv_window_controller
//   Sequences one convolution window. Interleaved data/filter words are popped
//   from a first-word-fall-through FIFO and loaded into a LANES-wide MAC array
//   over NUM_LOOP passes. Each lane's accumulated sum is then streamed to the
//   final adder. In hold mode a previously loaded kernel is replayed from the
//   local kernel store, and the FIFO supplies data words only.
//
// Ports
//   Clk, Rst            clock; asynchronous active-high reset
//   cStart, holdFilter  window request and kernel-reuse request (IDLE only)
//   FIFO_EMPTY/DATA     FIFO status and head word
//   FIFO_RD_EN          pop strobe, combinational from state and FIFO_EMPTY
//   MULTIPLIER_INPUT    per-lane data operand
//   MULTIPLICAND_INPUT  per-lane filter operand
//   MULTIPLY_CLEAR      accumulator clear pulse
//   MULTIPLY_START      per-lane start pulse
//   MULTIPLY_DONE       per-lane completion (pulse or level)
//   FLATSUMOUT          per-lane accumulator values
//   FINALADD/FINALADDEND  lane sum stream to the final adder
//   busy, cReady        activity flag and window-complete pulse
module conv_window_controller #(
  parameter int BIT_LEN  = 16,
  parameter int LANES    = 3,
  parameter int NUM_LOOP = 3
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         cStart,
  input  logic                         holdFilter,
  input  logic                         FIFO_EMPTY,
  input  logic [BIT_LEN-1:0]           FIFO_DATA,
  output logic                         FIFO_RD_EN,
  output logic [LANES*BIT_LEN-1:0]     MULTIPLIER_INPUT,
  output logic [LANES*BIT_LEN-1:0]     MULTIPLICAND_INPUT,
  output logic                         MULTIPLY_CLEAR,
  output logic [LANES-1:0]             MULTIPLY_START,
  input  logic [LANES-1:0]             MULTIPLY_DONE,
  input  logic [LANES*2*BIT_LEN-1:0]   FLATSUMOUT,
  output logic                         FINALADD,
  output logic [2*BIT_LEN-1:0]         FINALADDEND,
  output logic                         busy,
  output logic                         cReady
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW = (NUM_LOOP > 1) ? $clog2(NUM_LOOP) : 1;
  localparam int SW = 2 * BIT_LEN;
  localparam logic [LW-1:0] L_LAST = LW'(LANES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(NUM_LOOP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_READ, S_MULT, S_WAIT, S_ADD, S_DONE
  } state_t;

  state_t             state;
  logic               hold;
  logic               filter_valid;
  logic               t;
  logic [LW-1:0]      l;
  logic [PW-1:0]      p;
  logic [LANES-1:0]   done_q;
  logic [LANES-1:0]   done_seen;
  logic [BIT_LEN-1:0] kernel [NUM_LOOP][LANES];

  assign FIFO_RD_EN = (state == S_READ) && !FIFO_EMPTY;
  // A done bit already high on entry to WAIT counts immediately.
  assign done_seen  = done_q | MULTIPLY_DONE;

  // Kernel store: written by filter words in load mode, never reset.
  always_ff @(posedge Clk) begin
    if (FIFO_RD_EN && !hold && t) kernel[p][l] <= FIFO_DATA;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state              <= S_IDLE;
      hold               <= 1'b0;
      filter_valid       <= 1'b0;
      t                  <= 1'b0;
      l                  <= '0;
      p                  <= '0;
      done_q             <= '0;
      MULTIPLIER_INPUT   <= '0;
      MULTIPLICAND_INPUT <= '0;
      MULTIPLY_CLEAR     <= 1'b0;
      MULTIPLY_START     <= '0;
      FINALADD           <= 1'b0;
      FINALADDEND        <= '0;
      busy               <= 1'b0;
      cReady             <= 1'b0;
    end else begin
      MULTIPLY_CLEAR <= 1'b0;
      MULTIPLY_START <= '0;
      FINALADD       <= 1'b0;
      cReady         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cStart) begin
            hold           <= holdFilter && filter_valid;
            MULTIPLY_CLEAR <= 1'b1;
            busy           <= 1'b1;
            state          <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          p     <= '0;
          l     <= '0;
          t     <= 1'b0;
          state <= S_READ;
        end
        S_READ: begin
          if (FIFO_RD_EN) begin
            if (!hold && !t) begin
              MULTIPLIER_INPUT[l*BIT_LEN +: BIT_LEN] <= FIFO_DATA;
              t <= 1'b1;
            end else begin
              if (hold) begin
                MULTIPLIER_INPUT[l*BIT_LEN +: BIT_LEN]   <= FIFO_DATA;
                MULTIPLICAND_INPUT[l*BIT_LEN +: BIT_LEN] <= kernel[p][l];
              end else begin
                MULTIPLICAND_INPUT[l*BIT_LEN +: BIT_LEN] <= FIFO_DATA;
              end
              t <= 1'b0;
              if (l == L_LAST) begin
                l              <= '0;
                MULTIPLY_START <= '1;
                state          <= S_MULT;
              end else begin
                l <= l + 1'b1;
              end
            end
          end
        end
        // Multipliers running; a done arriving this cycle is kept.
        S_MULT: begin
          done_q <= MULTIPLY_DONE;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          done_q <= done_seen;
          if (&done_seen) begin
            if (p == P_LAST) begin
              // Lane 0 is presented on the first ADD cycle.
              l           <= '0;
              FINALADD    <= 1'b1;
              FINALADDEND <= FLATSUMOUT[0 +: SW];
              state       <= S_ADD;
            end else begin
              p     <= p + 1'b1;
              state <= S_READ;
            end
          end
        end
        // Sum streaming: FINALADDEND is fetched one lane ahead.
        S_ADD: begin
          if (l == L_LAST) begin
            cReady <= 1'b1;
            state  <= S_DONE;
          end else begin
            l           <= l + 1'b1;
            FINALADD    <= 1'b1;
            FINALADDEND <= FLATSUMOUT[(int'(l) + 1)*SW +: SW];
          end
        end
        S_DONE: begin
          if (!hold) filter_valid <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_controller.sv
module tb_conv_window_controller;
  localparam int BIT_LEN  = 16;
  localparam int LANES    = 3;
  localparam int NUM_LOOP = 3;
  localparam int SW       = 2 * BIT_LEN;
  localparam int NW       = LANES * NUM_LOOP;

  logic                       Clk = 1'b0;
  logic                       Rst = 1'b1;
  logic                       cStart = 1'b0;
  logic                       holdFilter = 1'b0;
  logic                       FIFO_EMPTY = 1'b1;
  logic [BIT_LEN-1:0]         FIFO_DATA = '0;
  logic                       FIFO_RD_EN;
  logic [LANES*BIT_LEN-1:0]   mul_in, mcand_in;
  logic                       mclr;
  logic [LANES-1:0]           mstart;
  logic [LANES-1:0]           mdone = '0;
  logic [LANES*SW-1:0]        flatsum = '0;
  logic                       finaladd;
  logic [SW-1:0]              addend;
  logic                       busy, cReady;

  conv_window_controller #(.BIT_LEN(BIT_LEN), .LANES(LANES), .NUM_LOOP(NUM_LOOP)) dut (
    .Clk(Clk), .Rst(Rst), .cStart(cStart), .holdFilter(holdFilter),
    .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA), .FIFO_RD_EN(FIFO_RD_EN),
    .MULTIPLIER_INPUT(mul_in), .MULTIPLICAND_INPUT(mcand_in),
    .MULTIPLY_CLEAR(mclr), .MULTIPLY_START(mstart), .MULTIPLY_DONE(mdone),
    .FLATSUMOUT(flatsum), .FINALADD(finaladd), .FINALADDEND(addend),
    .busy(busy), .cReady(cReady)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Environment: FIFO, multiplier/accumulator array and event counters.
  logic [BIT_LEN-1:0] fifo_q[$];
  logic [SW-1:0]      sums_q[$];
  logic               starve = 1'b0;
  int                 delay[LANES] = '{1, 1, 1};
  int                 cnt[LANES] = '{0, 0, 0};
  logic [SW-1:0]      acc[LANES] = '{0, 0, 0};
  int cyc = 0, rd_cnt = 0, start_cnt = 0, bad_start = 0, ready_cnt = 0, ready_cyc = 0, rd_empty = 0;
  logic                     mon_rd, mon_clr;
  logic [LANES-1:0]         mon_st;
  logic [LANES*BIT_LEN-1:0] mon_mi, mon_mc;

  always begin
    @(negedge Clk);
    cyc++;
    mon_rd  = FIFO_RD_EN;
    mon_clr = mclr;
    mon_st  = mstart;
    mon_mi  = mul_in;
    mon_mc  = mcand_in;
    if (FIFO_RD_EN && FIFO_EMPTY) rd_empty++;
    if (FIFO_RD_EN) rd_cnt++;
    if (mstart != '0) begin
      start_cnt++;
      if (mstart != '1) bad_start++;
    end
    if (finaladd) sums_q.push_back(addend);
    if (cReady) begin
      ready_cnt++;
      ready_cyc = cyc;
    end
    @(posedge Clk);
    #1;
    if (Rst) begin
      for (int i = 0; i < LANES; i++) begin
        acc[i] = '0;
        cnt[i] = 0;
      end
      mdone = '0;
    end else begin
      if (mon_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (mon_clr) for (int i = 0; i < LANES; i++) acc[i] = '0;
      for (int i = 0; i < LANES; i++) begin
        mdone[i] = 1'b0;
        if (mon_st[i]) begin
          acc[i] = acc[i] + SW'(mon_mi[i*BIT_LEN +: BIT_LEN]) * SW'(mon_mc[i*BIT_LEN +: BIT_LEN]);
          cnt[i] = delay[i];
        end
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) mdone[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < LANES; i++) flatsum[i*SW +: SW] = acc[i];
    FIFO_EMPTY = (fifo_q.size() == 0) || (starve && (cyc % 3 != 0));
    FIFO_DATA  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  // Reference: stored kernel and its validity, tracked per window.
  logic [BIT_LEN-1:0] ref_kernel[NW];
  logic               ref_valid = 1'b0;

  task automatic run_window(input string tag, input logic hreq,
                            input logic [BIT_LEN-1:0] dat[NW],
                            input logic [BIT_LEN-1:0] fil[NW],
                            output logic [SW-1:0] total);
    logic          use_hold;
    logic [SW-1:0] exp_sum[LANES];
    int rd0, st0, bs0, re0, r0, st_cyc, k, lat, maxd, base;
    use_hold = hreq && ref_valid;
    for (int i = 0; i < LANES; i++) begin
      exp_sum[i] = '0;
      for (int q = 0; q < NUM_LOOP; q++)
        exp_sum[i] = exp_sum[i] + SW'(dat[q*LANES+i]) *
                     SW'(use_hold ? ref_kernel[q*LANES+i] : fil[q*LANES+i]);
    end
    maxd = 1;
    for (int i = 0; i < LANES; i++) if (delay[i] > maxd) maxd = delay[i];
    base = 2 + NUM_LOOP * ((use_hold ? LANES : 2*LANES) + 1 + maxd) + LANES;
    for (int j = 0; j < NW; j++) begin
      fifo_q.push_back(dat[j]);
      if (!use_hold) fifo_q.push_back(fil[j]);
    end
    sums_q.delete();
    @(negedge Clk); #1;
    rd0 = rd_cnt; st0 = start_cnt; bs0 = bad_start; re0 = rd_empty; r0 = ready_cnt;
    holdFilter = hreq;
    cStart = 1'b1;
    st_cyc = cyc;
    @(negedge Clk); #1;
    cStart = 1'b0;
    holdFilter = 1'b0;
    k = 0;
    while (ready_cnt == r0 && k < 400) begin
      @(negedge Clk); #1;
      k++;
    end
    check_eq({tag, "_ready"}, 64'(ready_cnt - r0), 64'd1);
    lat = ready_cyc - st_cyc;
    if (starve) check_eq({tag, "_lat_grows"}, 64'(lat > base), 64'd1);
    else        check_eq({tag, "_latency"}, 64'(lat), 64'(base));
    @(negedge Clk); #1;
    check_eq({tag, "_ready_pulse"}, 64'(ready_cnt - r0), 64'd1);
    check_eq({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_nsums"}, 64'(sums_q.size()), 64'(LANES));
    total = '0;
    for (int i = 0; i < LANES; i++) begin
      check_eq($sformatf("%s_sum%0d", tag, i), (i < sums_q.size()) ? 64'(sums_q[i]) : 64'hx, 64'(exp_sum[i]));
      total = total + exp_sum[i];
    end
    check_eq({tag, "_words"}, 64'(rd_cnt - rd0), 64'(use_hold ? NW : 2*NW));
    check_eq({tag, "_starts"}, 64'(start_cnt - st0), 64'(NUM_LOOP));
    check_eq({tag, "_start_allones"}, 64'(bad_start - bs0), 64'd0);
    check_eq({tag, "_rd_while_empty"}, 64'(rd_empty - re0), 64'd0);
    check_eq({tag, "_fifo_drained"}, 64'(fifo_q.size()), 64'd0);
    if (!use_hold) begin
      ref_kernel = fil;
      ref_valid  = 1'b1;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_rd_en"}, 64'(FIFO_RD_EN), 64'd0);
    check_eq({tag, "_mul_in"}, 64'(mul_in), 64'd0);
    check_eq({tag, "_mcand_in"}, 64'(mcand_in), 64'd0);
    check_eq({tag, "_clear"}, 64'(mclr), 64'd0);
    check_eq({tag, "_start"}, 64'(mstart), 64'd0);
    check_eq({tag, "_finaladd"}, 64'(finaladd), 64'd0);
    check_eq({tag, "_addend"}, 64'(addend), 64'd0);
    check_eq({tag, "_cready"}, 64'(cReady), 64'd0);
  endtask

  initial begin
    logic [BIT_LEN-1:0] dat[NW];
    logic [BIT_LEN-1:0] fil[NW];
    logic [SW-1:0]      tot;
    int rd0, r0, k;
    for (int j = 0; j < NW; j++) begin
      dat[j] = BIT_LEN'(j + 1);
      fil[j] = BIT_LEN'(2);
    end
    repeat (3) @(negedge Clk);
    #1;
    check_zero_outputs("reset");
    Rst = 1'b0;
    repeat (2) @(negedge Clk);

    // Hold requested with no stored kernel: must run in load mode.
    run_window("nostore", 1'b1, dat, fil, tot);
    check_eq("nostore_total", 64'(tot), 64'd90);
    run_window("load", 1'b0, dat, fil, tot);
    check_eq("load_total", 64'(tot), 64'd90);
    run_window("hold", 1'b1, dat, fil, tot);
    check_eq("hold_total", 64'(tot), 64'd90);

    // FIFO starvation, fresh kernel.
    for (int j = 0; j < NW; j++) begin
      dat[j] = BIT_LEN'($urandom_range(0, 1000));
      fil[j] = BIT_LEN'($urandom_range(0, 1000));
    end
    starve = 1'b1;
    run_window("starve", 1'b0, dat, fil, tot);
    starve = 1'b0;

    // Lane 2 completes 5 cycles after lanes 0 and 1.
    delay = '{1, 1, 6};
    run_window("skew_hold", 1'b1, dat, fil, tot);
    run_window("skew_load", 1'b0, dat, fil, tot);
    delay = '{1, 1, 1};

    // Reset during the second READ pass.
    for (int j = 0; j < NW; j++) begin
      fifo_q.push_back(dat[j]);
      fifo_q.push_back(fil[j]);
    end
    @(negedge Clk); #1;
    rd0 = rd_cnt; r0 = ready_cnt;
    cStart = 1'b1;
    @(negedge Clk); #1;
    cStart = 1'b0;
    k = 0;
    while (rd_cnt - rd0 < 2*LANES + 1 && k < 200) begin
      @(negedge Clk); #1;
      k++;
    end
    check_eq("midrst_in_flight", 64'(busy), 64'd1);
    sums_q.delete();
    Rst = 1'b1;
    #1;
    check_zero_outputs("midrst");
    repeat (2) @(negedge Clk);
    #1;
    Rst = 1'b0;
    fifo_q.delete();
    ref_valid = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    check_eq("midrst_no_ready", 64'(ready_cnt - r0), 64'd0);
    check_eq("midrst_no_finaladd", 64'(sums_q.size()), 64'd0);
    run_window("after_rst", 1'b1, dat, fil, tot);

    // Randomized windows.
    for (int w = 0; w < 8; w++) begin
      for (int j = 0; j < NW; j++) begin
        dat[j] = BIT_LEN'($urandom);
        fil[j] = BIT_LEN'($urandom);
      end
      for (int i = 0; i < LANES; i++) delay[i] = $urandom_range(1, 4);
      starve = 1'($urandom_range(0, 1));
      run_window($sformatf("rand%0d", w), 1'($urandom_range(0, 1)), dat, fil, tot);
    end
    starve = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_window_controller.md
# conv_window_controller

Parametrised controller for one convolution window. It pulls interleaved data and filter words from a first-word-fall-through FIFO and loads them into a LANES-wide multiply-accumulate array over NUM_LOOP passes. It then streams each lane's accumulated sum to the final adder. It replaces the fixed 3x3 controller with a FIFO read-enable handshake (no gated clock), multiplier completion tracking, accumulator clear, and a filter-hold mode that re-uses a stored kernel.

## Interface
- BIT_LEN, 16, operand width; sums are 2*BIT_LEN.
- LANES, 3, multiplier lanes (taps per pass).
- NUM_LOOP, 3, passes per window (kernel = LANES x NUM_LOOP).
- Clk  in  1  clock; all state changes on rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- cStart  in  1  start request, sampled in IDLE only.
- holdFilter  in  1  sampled with cStart: 1 = re-use the stored kernel, FIFO supplies data words only.
- FIFO_EMPTY  in  1  FIFO empty; FIFO_DATA is valid when low.
- FIFO_DATA  in  BIT_LEN  FIFO head word.
- FIFO_RD_EN  out  1  pop; the word is consumed in the cycle this is high.
- MULTIPLIER_INPUT  out  LANES*BIT_LEN  data operand per lane; lane i at [i*BIT_LEN +: BIT_LEN].
- MULTIPLICAND_INPUT  out  LANES*BIT_LEN  filter operand per lane.
- MULTIPLY_CLEAR  out  1  one-cycle pulse that clears lane accumulators.
- MULTIPLY_START  out  LANES  one-cycle start pulse per lane.
- MULTIPLY_DONE  in  LANES  per-lane completion pulse or level.
- FLATSUMOUT  in  LANES*2*BIT_LEN  lane accumulator values.
- FINALADD  out  1  FINALADDEND is valid this cycle.
- FINALADDEND  out  2*BIT_LEN  lane sum presented to the final adder.
- busy  out  1  high in every state except IDLE.
- cReady  out  1  one-cycle window-complete pulse.

## Operation
- States: IDLE, CLEAR, READ, MULT, WAIT, ADD, DONE.
- IDLE
  - On cStart=1, latch mode: hold = holdFilter AND filterValid.
  - Go to CLEAR.
- CLEAR
  - MULTIPLY_CLEAR=1 for this cycle.
  - Pass counter p=0, lane pointer l=0, toggle t=0.
  - Go to READ.
- READ
  - FIFO_RD_EN = (state==READ) AND !FIFO_EMPTY; the only path is combinational from state and FIFO_EMPTY.
  - Load mode:
    - t=0: the word goes to MULTIPLIER_INPUT lane l.
    - t=1: the word goes to MULTIPLICAND_INPUT lane l and to kernel store [p][l]; then l++.
  - Hold mode:
    - Each word goes to MULTIPLIER_INPUT lane l.
    - MULTIPLICAND_INPUT lane l is loaded from kernel store [p][l] in the same edge; then l++.
  - When lane LANES-1 completes: l=0, go to MULT.
  - While FIFO_EMPTY=1, stay in READ with no state change.
- MULT
  - MULTIPLY_START = all ones for exactly one cycle.
  - Clear the sticky done register; go to WAIT.
- WAIT
  - Sticky-OR MULTIPLY_DONE into the done register.
  - When all LANES bits are set: if p==NUM_LOOP-1, go to ADD with l=0; else p++ and go to READ.
- ADD
  - Each cycle: FINALADD=1, FINALADDEND = FLATSUMOUT[l*2*BIT_LEN +: 2*BIT_LEN], l++.
  - After lane LANES-1, go to DONE.
- DONE
  - cReady=1 for one cycle.
  - filterValid=1 if this window ran in load mode.
  - Go to IDLE.
- Operands hold their values between windows; they change only in READ.
- cStart outside IDLE is ignored.
- cStart held high re-triggers from IDLE on the cycle after DONE.
- holdFilter=1 with filterValid=0 runs in load mode. No error is raised.
- Reset value of every output is 0: operands, FINALADDEND, FINALADD, MULTIPLY_START, MULTIPLY_CLEAR, cReady, busy, FIFO_RD_EN.
- Reset also forces state=IDLE, counters=0, filterValid=0. The kernel store is not cleared.
- Rst mid-window abandons the window. Popped words are lost, and no cReady or FINALADD is issued.

## Timing
- IDLE to CLEAR: the edge after cStart is sampled. CLEAR lasts 1 cycle.
- READ per pass with a non-empty FIFO: 2*LANES cycles in load mode, LANES in hold mode.
- MULT: 1 cycle. WAIT: at least 1 cycle; it exits on the edge after the last done bit is seen.
- ADD: LANES cycles. DONE: 1 cycle.
- Minimum window latency, cStart to cReady, with 1-cycle multipliers:
  - load mode: 2 + NUM_LOOP*(2*LANES+2) + LANES cycles;
  - hold mode: 2 + NUM_LOOP*(LANES+2) + LANES cycles.
- MULTIPLY_DONE arriving in the MULT cycle is captured.
- A done bit that is already high entering WAIT counts toward completion.

## Test plan
- Load mode, defaults, FIFO never empty:
  - stimulus: data 1..9 interleaved with filter 2, behavioural MAC model;
  - response: FINALADDEND = 24, 30, 36 on 3 consecutive FINALADD cycles (total 90), then cReady for 1 cycle, 2+3*8+3=29 cycles after cStart.
- Hold mode, following that window:
  - stimulus: data 1..9 only, FIFO supplies 9 words;
  - response: same sums 24, 30, 36; FIFO_RD_EN high for exactly 9 cycles.
- FIFO starvation:
  - stimulus: drop FIFO_EMPTY low for 1 cycle in every 3;
  - response: FIFO_RD_EN is never high while FIFO_EMPTY=1; sums are unchanged; latency grows by the stall count.
- Slow, skewed multipliers:
  - stimulus: lane 2 done 5 cycles after lanes 0 and 1;
  - response: the next READ starts only after lane 2 is done; MULTIPLY_START pulses exactly 3 times per window.
- Hold request with nothing stored:
  - stimulus: holdFilter=1 and cStart immediately after reset;
  - response: load mode runs, consuming 18 words.
- Reset mid-window:
  - stimulus: Rst asserted in the second READ pass;
  - response: all outputs 0 asynchronously, no cReady; a fresh window then completes correctly.
